waveform_capture: RTL and testbench

- Wishbone initiator that records ADC samples into RAM; the capture-direction counterpart of the waveform output generator.
- Each sample: arm the SPI master, poll its blocking status register, read the received word, disarm, then write the word to RAM.
- Sits between the SPI master register bank and the shared RAM. Software controls it through run, do_loop and buf_size, and reads samples back from RAM.

---
 rtl/waveform_capture.sv | 188 ++++++++++++++++++
 tb/tb_waveform_capture.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_capture.sv
// Wishbone initiator: per sample arms the SPI master, polls status, reads the word, disarms, stores it to RAM.
// Latency: 5 bus transactions + idle gaps + (timer_spacing+1) cycles per sample; wb_ack wait states stall the sequence indefinitely.
module waveform_capture #(
    parameter logic [31:0] RAM_START_ADDR  = 32'h0000_0000,
    parameter logic [31:0] SPI_START_ADDR  = 32'h1000_0000,
    parameter int          COUNTER_MAX_WID = 16,
    parameter int          TIMER_WID       = 16
) (
    input  logic                       clk,
    input  logic                       rst_L,
    input  logic                       run,
    input  logic                       do_loop,
    input  logic [COUNTER_MAX_WID-1:0] buf_size,
    input  logic [TIMER_WID-1:0]       timer_spacing,
    output logic [COUNTER_MAX_WID-1:0] cntr,
    output logic [TIMER_WID-1:0]       timer,
    output logic                       ready,
    output logic                       finished,
    output logic [31:0]                wb_adr,
    output logic                       wb_cyc,
    output logic                       wb_stb,
    output logic                       wb_we,
    output logic [31:0]                wb_dat_w,
    output logic [3:0]                 wb_sel,
    input  logic [31:0]                wb_dat_r,
    input  logic                       wb_ack
);

    localparam logic [31:0] SPI_ARM_ADDR    = SPI_START_ADDR | 32'h0000_0004;
    localparam logic [31:0] SPI_RX_ADDR     = SPI_START_ADDR | 32'h0000_0008;
    localparam logic [31:0] SPI_STATUS_ADDR = SPI_START_ADDR | 32'h0000_0010;
    localparam logic [COUNTER_MAX_WID-1:0] CNT_ONE = COUNTER_MAX_WID'(1);
    localparam logic [TIMER_WID-1:0]       TMR_ONE = TIMER_WID'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_POLL,
        S_READ,
        S_DISARM,
        S_STORE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                     state;
    logic [31:0]                sample_dat;
    logic [COUNTER_MAX_WID-1:0] last_idx;
    logic                       bus_state;
    logic                       bus_done;
    logic [31:0]                req_adr;
    logic                       req_we;
    logic [31:0]                req_dat;

    assign ready    = (state == S_IDLE);
    assign wb_sel   = 4'b1111;
    assign bus_done = wb_cyc & wb_ack;
    // Live compare: a buf_size shrunk below cntr lets the counter run to its natural wrap.
    assign last_idx = buf_size - CNT_ONE;

    always_comb begin
        bus_state = 1'b0;
        req_adr   = 32'h0;
        req_we    = 1'b0;
        req_dat   = 32'h0;
        case (state)
            S_ARM: begin
                bus_state = 1'b1;
                req_adr   = SPI_ARM_ADDR;
                req_we    = 1'b1;
                req_dat   = 32'h1;
            end
            S_POLL: begin
                bus_state = 1'b1;
                req_adr   = SPI_STATUS_ADDR;
            end
            S_READ: begin
                bus_state = 1'b1;
                req_adr   = SPI_RX_ADDR;
            end
            S_DISARM: begin
                bus_state = 1'b1;
                req_adr   = SPI_ARM_ADDR;
                req_we    = 1'b1;
            end
            S_STORE: begin
                bus_state = 1'b1;
                req_adr   = RAM_START_ADDR + (32'(cntr) << 2);
                req_we    = 1'b1;
                req_dat   = sample_dat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state      <= S_IDLE;
            cntr       <= '0;
            timer      <= '0;
            finished   <= 1'b0;
            sample_dat <= 32'h0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_adr     <= 32'h0;
            wb_dat_w   <= 32'h0;
        end else begin
            // A bus state entered with cyc low launches its transaction; the cycle after
            // an ack therefore always sees cyc low, giving the mandatory idle gap.
            if (bus_state && !wb_cyc) begin
                wb_cyc   <= 1'b1;
                wb_stb   <= 1'b1;
                wb_adr   <= req_adr;
                wb_we    <= req_we;
                wb_dat_w <= req_dat;
            end else if (bus_done) begin
                wb_cyc <= 1'b0;
                wb_stb <= 1'b0;
                wb_we  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (run) begin
                        cntr <= '0;
                        if (buf_size == '0) begin
                            state    <= S_DONE;
                            finished <= 1'b1;
                        end else begin
                            state <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (bus_done) state <= S_POLL;
                end
                S_POLL: begin
                    if (bus_done && wb_dat_r[1]) state <= S_READ;
                end
                S_READ: begin
                    if (bus_done) begin
                        sample_dat <= wb_dat_r;
                        state      <= S_DISARM;
                    end
                end
                S_DISARM: begin
                    if (bus_done) state <= S_STORE;
                end
                S_STORE: begin
                    if (bus_done) begin
                        timer <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (timer == timer_spacing) begin
                        timer <= '0;
                        if (!run) begin
                            state <= S_IDLE;
                        end else if (cntr == last_idx) begin
                            if (do_loop) begin
                                cntr  <= '0;
                                state <= S_ARM;
                            end else begin
                                state    <= S_DONE;
                                finished <= 1'b1;
                            end
                        end else begin
                            cntr  <= cntr + CNT_ONE;
                            state <= S_ARM;
                        end
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                S_DONE: begin
                    if (!run) begin
                        finished <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_waveform_capture.sv
// Bench for waveform_capture: random-latency SPI/RAM responder checks every bus transaction
// against an expected per-sample transaction list built from the capture rules.
`timescale 1ns/1ps
module tb_waveform_capture;

    localparam logic [31:0] SPI   = 32'h1000_0000;
    localparam logic [31:0] ARM_A = SPI + 32'h4;
    localparam logic [31:0] FS_A  = SPI + 32'h8;
    localparam logic [31:0] ST_A  = SPI + 32'h10;

    logic        clk = 1'b0;
    logic        rst_L = 1'b0;
    logic        run = 1'b0;
    logic        do_loop = 1'b0;
    logic [15:0] buf_size = 16'h0;
    logic [15:0] timer_spacing = 16'h0;
    logic [15:0] cntr;
    logic [15:0] timer;
    logic        ready;
    logic        finished;
    logic [31:0] wb_adr;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_r = 32'h0;
    logic        wb_ack = 1'b0;

    always #5 clk = ~clk;

    waveform_capture dut (
        .clk           (clk),
        .rst_L         (rst_L),
        .run           (run),
        .do_loop       (do_loop),
        .buf_size      (buf_size),
        .timer_spacing (timer_spacing),
        .cntr          (cntr),
        .timer         (timer),
        .ready         (ready),
        .finished      (finished),
        .wb_adr        (wb_adr),
        .wb_cyc        (wb_cyc),
        .wb_stb        (wb_stb),
        .wb_we         (wb_we),
        .wb_dat_w      (wb_dat_w),
        .wb_sel        (wb_sel),
        .wb_dat_r      (wb_dat_r),
        .wb_ack        (wb_ack)
    );

    // gap: idle cyc cycles required before this transaction (0 = not checked)
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [15:0] gap;
    } txn_t;

    txn_t        exp_q[$];
    int          polls_q[$];
    logic [31:0] samples_q[$];
    logic [31:0] ram[int];
    logic [31:0] exp_ram[int];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Responder: SPI register bank + RAM with random wait states.
    int          idle_cnt = 0;
    int          pend_polls = 0;
    int          lat = 0;
    int          arms_cnt = 0;
    int          status_cnt = 0;
    int          stores_cnt = 0;
    int          txn_cnt = 0;
    int          hold_from = 0;
    bit          in_txn = 1'b0;
    bit          hold_store = 1'b0;
    bit          fin_seen = 1'b0;
    logic [31:0] cur_adr = 32'h0;
    txn_t        cur_exp;

    always @(negedge clk) begin
        if (finished) fin_seen = 1'b1;
        if (wb_ack) begin
            wb_ack = 1'b0;
            check_eq("cyc_drop", {63'h0, wb_cyc}, 64'h0);
        end
        if (!wb_cyc) begin
            idle_cnt++;
        end else if (wb_stb) begin
            if (!in_txn) begin
                in_txn  = 1'b1;
                txn_cnt++;
                cur_adr = wb_adr;
                lat     = $urandom_range(0, 3);
                check_eq("sel", {60'h0, wb_sel}, 64'hF);
                if (exp_q.size() == 0) begin
                    check_eq("txn_expected", 64'(exp_q.size()), 64'h1);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check_eq("txn_we",  {63'h0, wb_we}, {63'h0, cur_exp.we});
                    check_eq("txn_adr", {32'h0, wb_adr}, {32'h0, cur_exp.adr});
                    check_eq("txn_dat", {32'h0, wb_dat_w}, {32'h0, cur_exp.dat});
                    if (cur_exp.gap != 16'h0)
                        check_eq("txn_gap", 64'(idle_cnt), {48'h0, cur_exp.gap});
                end
                idle_cnt = 0;
                if (wb_we && wb_adr == ARM_A && wb_dat_w == 32'h1) begin
                    arms_cnt++;
                    pend_polls = (polls_q.size() > 0) ? polls_q.pop_front() : 0;
                end
                if (!wb_we && wb_adr == ST_A) status_cnt++;
                if (wb_we && wb_adr < SPI) stores_cnt++;
            end else begin
                check_eq("adr_hold", {32'h0, wb_adr}, {32'h0, cur_adr});
            end
            if (!(hold_store && wb_we && wb_adr < SPI && stores_cnt >= hold_from)) begin
                if (lat == 0) begin
                    wb_dat_r = $urandom;
                    if (!wb_we && wb_adr == ST_A) begin
                        if (pend_polls > 0) begin
                            pend_polls--;
                            wb_dat_r = 32'h1;
                        end else begin
                            wb_dat_r = 32'h2 | 32'($urandom_range(0, 1));
                        end
                    end else if (!wb_we && wb_adr == FS_A) begin
                        wb_dat_r = (samples_q.size() > 0) ? samples_q.pop_front() : 32'hBAD0_BAD0;
                    end else if (wb_we && wb_adr < SPI) begin
                        ram[int'(wb_adr >> 2)] = wb_dat_w;
                    end
                    wb_ack = 1'b1;
                    in_txn = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
    end

    // One sample = arm, (k not-ready polls + 1 ready poll), from_slave read, disarm, RAM store.
    task automatic expect_sample(input int idx, input int gap);
        int          k;
        logic [31:0] v;
        k = $urandom_range(0, 2);
        v = $urandom;
        polls_q.push_back(k);
        samples_q.push_back(v);
        exp_ram[idx] = v;
        exp_q.push_back('{1'b1, ARM_A, 32'h1, 16'(gap)});
        for (int p = 0; p <= k; p++) exp_q.push_back('{1'b0, ST_A, 32'h0, 16'h1});
        exp_q.push_back('{1'b0, FS_A, 32'h0, 16'h1});
        exp_q.push_back('{1'b1, ARM_A, 32'h0, 16'h1});
        exp_q.push_back('{1'b1, 32'(idx) << 2, v, 16'h1});
    endtask

    function automatic logic [63:0] ram_word(input int idx);
        return ram.exists(idx) ? {32'h0, ram[idx]} : 64'h1_0000_0000;
    endfunction

    task automatic wait_ready(input string tag);
        for (int c = 0; c < 2000 && !ready; c++) @(negedge clk);
        check_eq(tag, {63'h0, ready}, 64'h1);
    endtask

    task automatic capture_pass(input int bs, input int ts);
        buf_size      = 16'(bs);
        timer_spacing = 16'(ts);
        do_loop       = 1'b0;
        ram.delete();
        exp_ram.delete();
        for (int i = 0; i < bs; i++) expect_sample(i, (i == 0) ? 0 : ts + 2);
        run = 1'b1;
        for (int c = 0; c < 4000 && !finished; c++) @(negedge clk);
        check_eq("pass_finished", {63'h0, finished}, 64'h1);
        check_eq("pass_ready_low", {63'h0, ready}, 64'h0);
        check_eq("pass_cntr", {48'h0, cntr}, 64'(bs - 1));
        check_eq("pass_pending", 64'(exp_q.size()), 64'h0);
        for (int i = 0; i < bs; i++) check_eq("pass_ram", ram_word(i), {32'h0, exp_ram[i]});
        run = 1'b0;
        @(negedge clk);
        check_eq("pass_ready", {63'h0, ready}, 64'h1);
        check_eq("pass_fin_clr", {63'h0, finished}, 64'h0);
    endtask

    initial begin
        int base;
        int ts;
        #3;
        check_eq("rst_ready", {63'h0, ready}, 64'h1);
        check_eq("rst_finished", {63'h0, finished}, 64'h0);
        check_eq("rst_cntr", {48'h0, cntr}, 64'h0);
        check_eq("rst_timer", {48'h0, timer}, 64'h0);
        check_eq("rst_bus", {61'h0, wb_cyc, wb_stb, wb_we}, 64'h0);
        check_eq("rst_adr_dat", {wb_adr, wb_dat_w}, 64'h0);
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);

        // Basic capture, then random sizes and spacings, then zero spacing.
        capture_pass(3, 2);
        for (int it = 0; it < 4; it++) capture_pass($urandom_range(1, 4), $urandom_range(0, 3));
        capture_pass(2, 0);

        // Loop mode: five samples alternating between words 0 and 1.
        ts = $urandom_range(0, 2);
        buf_size      = 16'd2;
        timer_spacing = 16'(ts);
        do_loop       = 1'b1;
        ram.delete();
        exp_ram.delete();
        for (int s = 0; s < 5; s++) expect_sample(s % 2, (s == 0) ? 0 : ts + 2);
        base     = stores_cnt;
        fin_seen = 1'b0;
        run      = 1'b1;
        for (int c = 0; c < 5000 && stores_cnt < base + 5; c++) @(negedge clk);
        check_eq("loop_stores", 64'(stores_cnt - base), 64'd5);
        run = 1'b0;
        wait_ready("loop_ready");
        check_eq("loop_cntr", {48'h0, cntr}, 64'h0);
        check_eq("loop_fin_seen", {63'h0, fin_seen}, 64'h0);
        check_eq("loop_pending", 64'(exp_q.size()), 64'h0);
        check_eq("loop_ram0", ram_word(0), {32'h0, exp_ram[0]});
        check_eq("loop_ram1", ram_word(1), {32'h0, exp_ram[1]});
        do_loop = 1'b0;

        // Abort: run dropped while sample 1 is polling; sample 1 still lands at 0x4.
        ts = $urandom_range(0, 3);
        buf_size      = 16'd4;
        timer_spacing = 16'(ts);
        ram.delete();
        exp_ram.delete();
        expect_sample(0, 0);
        expect_sample(1, ts + 2);
        base     = arms_cnt;
        fin_seen = 1'b0;
        run      = 1'b1;
        for (int c = 0; c < 3000 && arms_cnt < base + 2; c++) @(negedge clk);
        base = status_cnt;
        for (int c = 0; c < 100 && status_cnt == base; c++) @(negedge clk);
        run = 1'b0;
        wait_ready("abort_ready");
        check_eq("abort_cntr", {48'h0, cntr}, 64'h1);
        check_eq("abort_fin", {63'h0, fin_seen}, 64'h0);
        check_eq("abort_pending", 64'(exp_q.size()), 64'h0);
        check_eq("abort_ram1", ram_word(1), {32'h0, exp_ram[1]});

        // Zero-length buffer: DONE right after run, no bus traffic.
        buf_size = 16'd0;
        base     = txn_cnt;
        run      = 1'b1;
        @(negedge clk);
        check_eq("zero_finished", {63'h0, finished}, 64'h1);
        check_eq("zero_ready", {63'h0, ready}, 64'h0);
        check_eq("zero_cntr", {48'h0, cntr}, 64'h0);
        repeat (3) @(negedge clk);
        check_eq("zero_no_txn", 64'(txn_cnt - base), 64'h0);
        run = 1'b0;
        @(negedge clk);
        check_eq("zero_idle", {63'h0, ready}, 64'h1);

        // Reset while the sample-1 store waits for ack.
        buf_size      = 16'd3;
        timer_spacing = 16'd1;
        expect_sample(0, 0);
        expect_sample(1, 3);
        base       = stores_cnt;
        hold_from  = base + 2;
        hold_store = 1'b1;
        run        = 1'b1;
        for (int c = 0; c < 3000 && stores_cnt < base + 2; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_eq("hold_cyc", {63'h0, wb_cyc}, 64'h1);
        check_eq("hold_cntr", {48'h0, cntr}, 64'h1);
        #2 rst_L = 1'b0;
        #1;
        check_eq("arst_cyc", {62'h0, wb_cyc, wb_stb}, 64'h0);
        check_eq("arst_ready", {63'h0, ready}, 64'h1);
        check_eq("arst_cntr", {48'h0, cntr}, 64'h0);
        check_eq("arst_timer", {48'h0, timer}, 64'h0);
        check_eq("arst_pending", 64'(exp_q.size()), 64'h0);
        in_txn     = 1'b0;
        hold_store = 1'b0;
        run        = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        capture_pass(2, $urandom_range(0, 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
